// File: rtl/fast_gpio_pkg.sv
// Shared constants for the fast GPIO sequencer: register map, CTRL/STATUS
// bit positions and the sequencer state encoding.
package fast_gpio_pkg;

  localparam int ADDR_CTRL     = 'h00;
  localparam int ADDR_DIR      = 'h01;
  localparam int ADDR_DIV      = 'h02;
  localparam int ADDR_LEN      = 'h03;
  localparam int ADDR_STATUS   = 'h04;
  localparam int ADDR_IRQ_MASK = 'h05;
  localparam int ADDR_OUT_BASE = 'h10;
  localparam int ADDR_IN_BASE  = 'h20;

  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;
  localparam int CTRL_MODE  = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_WRAP    = 2;
  localparam int STAT_IDX_LSB = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/fast_gpio_seq_if.sv
// Select/wen/ren register bus between the host and the fast GPIO sequencer.
interface fast_gpio_if #(
  parameter int AW    = 8,
  parameter int WIDTH = 32
);
  logic             sel;
  logic             wen;
  logic             ren;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             rvalid;

  modport master (output sel, wen, ren, addr, wdata, input rdata, rvalid);
  modport slave  (input sel, wen, ren, addr, wdata, output rdata, rvalid);
endinterface

// File: rtl/fast_gpio_sync.sv
// Two-flop synchroniser bringing the asynchronous pad inputs into clk.
module fast_gpio_sync #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/fast_gpio_seq.sv
// Fast GPIO sequencer: steps DEPTH output/capture slots at a programmable rate.
// Optional IRQ_MASK register and irq output when FAST_GPIO_IRQ_EN is defined.
//
//   state | meaning
//   IDLE  | sequencer stopped, gpio_out holds its last value
//   RUN   | stepping slots every DIV+1 cycles, capturing pins at slot end
module fast_gpio_seq
  import fast_gpio_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  fast_gpio_if.slave       bus,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             busy
`ifdef FAST_GPIO_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LEN_W = IDX_W + 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_sh_q, div_sh_d;
  logic [LEN_W-1:0] len_sh_q, len_sh_d;
  logic [WIDTH-1:0] out_q [DEPTH];
  logic [WIDTH-1:0] out_d [DEPTH];
  logic [WIDTH-1:0] in_q [DEPTH];
  logic [WIDTH-1:0] in_d [DEPTH];
  logic [WIDTH-1:0] gpio_out_q, gpio_out_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
`ifdef FAST_GPIO_IRQ_EN
  logic [1:0]       mask_q, mask_d;
  logic             irq_q, irq_d;
`endif

  logic [WIDTH-1:0] gpio_sync;
  logic             wr, rd, start, stop;
  logic [AW-1:0]    a;
  logic             out_hit, in_hit;
  logic [IDX_W-1:0] out_idx, in_idx;
  logic [LEN_W-1:0] len_eff;
  logic             last_slot;
  logic [WIDTH-1:0] rd_val;

  fast_gpio_sync #(.WIDTH(WIDTH)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (gpio_in),
    .q     (gpio_sync)
  );

  always_comb begin
    a       = bus.addr;
    wr      = bus.sel & bus.wen;
    rd      = bus.sel & bus.ren;
    start   = wr && (a == AW'(ADDR_CTRL)) && bus.wdata[CTRL_START];
    stop    = wr && (a == AW'(ADDR_CTRL)) && bus.wdata[CTRL_STOP];
    out_hit = (a >= AW'(ADDR_OUT_BASE)) && (a < AW'(ADDR_OUT_BASE + DEPTH));
    in_hit  = (a >= AW'(ADDR_IN_BASE)) && (a < AW'(ADDR_IN_BASE + DEPTH));
    out_idx = IDX_W'(a - AW'(ADDR_OUT_BASE));
    in_idx  = IDX_W'(a - AW'(ADDR_IN_BASE));
    // Zero or oversize lengths mean "use every slot".
    if ((len_q == '0) || (len_q > WIDTH'(DEPTH))) len_eff = LEN_W'(DEPTH);
    else                                         len_eff = LEN_W'(len_q);
    last_slot = ({1'b0, idx_q} == (len_sh_q - 1'b1));
  end

  always_comb begin
    rd_val = '0;
    case (a)
      AW'(ADDR_DIR):    rd_val = dir_q;
      AW'(ADDR_DIV):    rd_val = WIDTH'(div_q);
      AW'(ADDR_LEN):    rd_val = len_q;
      AW'(ADDR_STATUS): begin
        rd_val[STAT_BUSY]            = (state_q == RUN);
        rd_val[STAT_DONE]            = done_q;
        rd_val[STAT_WRAP]            = wrap_q;
        rd_val[STAT_IDX_LSB +: 4]    = 4'(idx_q);
      end
`ifdef FAST_GPIO_IRQ_EN
      AW'(ADDR_IRQ_MASK): rd_val = WIDTH'(mask_q);
`endif
      default: begin
        if (out_hit)     rd_val = out_q[out_idx];
        else if (in_hit) rd_val = in_q[in_idx];
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    div_d      = div_q;
    len_d      = len_q;
    mode_d     = mode_q;
    done_d     = done_q;
    wrap_d     = wrap_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    div_sh_d   = div_sh_q;
    len_sh_d   = len_sh_q;
    out_d      = out_q;
    in_d       = in_q;
    gpio_out_d = gpio_out_q;
    rvalid_d   = rd;
    rdata_d    = rd ? rd_val : rdata_q;
`ifdef FAST_GPIO_IRQ_EN
    mask_d     = mask_q;
    irq_d      = (done_q & mask_q[0]) | (wrap_q & mask_q[1]);
`endif

    if (wr) begin
      case (a)
        AW'(ADDR_CTRL): mode_d = bus.wdata[CTRL_MODE];
        AW'(ADDR_DIR):  dir_d  = bus.wdata;
        AW'(ADDR_DIV):  div_d  = bus.wdata[DIV_W-1:0];
        AW'(ADDR_LEN):  len_d  = bus.wdata;
        AW'(ADDR_STATUS): begin
          if (bus.wdata[STAT_DONE]) done_d = 1'b0;
          if (bus.wdata[STAT_WRAP]) wrap_d = 1'b0;
        end
`ifdef FAST_GPIO_IRQ_EN
        AW'(ADDR_IRQ_MASK): mask_d = bus.wdata[1:0];
`endif
        default: if (out_hit) out_d[out_idx] = bus.wdata;
      endcase
    end

    // Flag sets below come after the write-1 clears so a coincident set wins.
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d    = RUN;
          div_sh_d   = div_q;
          len_sh_d   = len_eff;
          idx_d      = '0;
          cnt_d      = '0;
          gpio_out_d = out_q[0];
          done_d     = 1'b0;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (start) begin
          div_sh_d   = div_q;
          len_sh_d   = len_eff;
          idx_d      = '0;
          cnt_d      = '0;
          gpio_out_d = out_q[0];
          done_d     = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == div_sh_q) begin
            in_d[idx_q] = gpio_sync;
            cnt_d       = '0;
            if (!last_slot) begin
              idx_d      = idx_q + 1'b1;
              gpio_out_d = out_q[idx_q + 1'b1];
            end else if (!mode_q) begin
              idx_d      = '0;
              gpio_out_d = out_q[0];
              wrap_d     = 1'b1;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      dir_q      <= '0;
      div_q      <= '0;
      len_q      <= '0;
      mode_q     <= 1'b0;
      done_q     <= 1'b0;
      wrap_q     <= 1'b0;
      idx_q      <= '0;
      cnt_q      <= '0;
      div_sh_q   <= '0;
      len_sh_q   <= '0;
      gpio_out_q <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        out_q[i] <= '0;
        in_q[i]  <= '0;
      end
`ifdef FAST_GPIO_IRQ_EN
      mask_q     <= '0;
      irq_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      div_q      <= div_d;
      len_q      <= len_d;
      mode_q     <= mode_d;
      done_q     <= done_d;
      wrap_q     <= wrap_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      div_sh_q   <= div_sh_d;
      len_sh_q   <= len_sh_d;
      gpio_out_q <= gpio_out_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      for (int i = 0; i < DEPTH; i++) begin
        out_q[i] <= out_d[i];
        in_q[i]  <= in_d[i];
      end
`ifdef FAST_GPIO_IRQ_EN
      mask_q     <= mask_d;
      irq_q      <= irq_d;
`endif
    end
  end

  assign gpio_out   = gpio_out_q;
  assign gpio_oe    = dir_q;
  assign busy       = (state_q == RUN);
  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
`ifdef FAST_GPIO_IRQ_EN
  assign irq        = irq_q;
`endif

endmodule

// File: doc/fast_gpio_seq.md
Name: fast_gpio_seq

Overview:
- Second-generation fast GPIO block.
- Holds DEPTH output pattern slots and DEPTH input capture slots. A prescaled sequencer steps through the slots, driving each output pattern onto the pins and capturing the pins at the end of each slot.
- Generalises the fixed 4-slot, 32-bit, write-triggered rotation to parametrised width, depth and length, with a programmable slot rate, continuous or one-shot mode, and registered bus reads.
- Sits between the simple select/wen/ren register bus and the pad ring.

Parameters:
- WIDTH, 32: GPIO pin count and bus data width.
- DEPTH, 4: number of OUT/IN slots; power of two, 2..16.
- AW, 8: bus address width.
- DIV_W, 16: prescaler width.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- sel  in  1  block select.
- wen  in  1  write enable; qualified by sel.
- ren  in  1  read enable; qualified by sel.
- addr  in  AW  register address.
- wdata  in  WIDTH  write data.
- rdata  out  WIDTH  registered read data.
- rvalid  out  1  one-cycle pulse when rdata is updated.
- gpio_in  in  WIDTH  pad inputs; asynchronous to clk.
- gpio_out  out  WIDTH  pad output values.
- gpio_oe  out  WIDTH  pad output enables; 1 = drive.
- busy  out  1  high while the sequencer is running.

Behaviour:
- Register map:
  - 0x00 CTRL (write-only strobes). bit0 START, bit1 STOP, bit2 MODE (0 = continuous, 1 = one-shot). MODE is stored.
  - 0x01 DIR, read/write. Drives gpio_oe directly.
  - 0x02 DIV, read/write, DIV_W bits.
  - 0x03 LEN, read/write. Value 0 or greater than DEPTH is treated as DEPTH.
  - 0x04 STATUS. bit0 busy, bit1 done (sticky), bit2 wrap (sticky), bits[7:4] current idx. Writing 1 to bit1 or bit2 clears that flag.
  - 0x10+i OUT[i], read/write.
  - 0x20+i IN[i], read-only.
  - Unmapped reads return 0; unmapped writes are ignored.
- Bus:
  - A write takes effect at the clock edge where sel & wen.
  - sel & ren: rdata is loaded at that edge and rvalid pulses high for one cycle. rdata holds its value until the next read.
  - Read and write to the same address in the same cycle: rdata returns the pre-write value.
- gpio_in passes through a 2-flop synchroniser (2-cycle latency). Captures always use the synchronised value.
- Reset (asynchronous, effective mid-operation):
  - All registers, IN/OUT slots, gpio_out, gpio_oe, rdata, rvalid, busy and idx go to 0.
  - State goes to IDLE.
- State machine IDLE/RUN:
  - IDLE + START → RUN. At that edge: shadow copies of DIV and LEN are latched; idx=0; cnt=0; gpio_out<=OUT[0]; done cleared.
  - RUN: each slot lasts DIV+1 cycles, and cnt increments every cycle. At the edge where cnt==DIV:
    - IN[idx] is captured from the synchronised pins;
    - cnt resets to 0;
    - if idx < LEN-1: idx increments and gpio_out<=OUT[idx+1];
    - if idx == LEN-1 in continuous mode: idx=0, gpio_out<=OUT[0], wrap set;
    - if idx == LEN-1 in one-shot mode: go to IDLE, set done, gpio_out holds OUT[LEN-1].
  - STOP: go to IDLE at the write edge. No capture; gpio_out holds its value; done is not set.
  - START while in RUN restarts from idx 0.
  - START and STOP in the same write: STOP wins.
- Writes during RUN:
  - A write to OUT[i] takes effect the next time slot i is loaded.
  - Writes to DIV and LEN update the registers but not the shadow copies.
- busy = (state == RUN).
- A write-1 clear of a sticky flag coinciding with its set event: set wins.

Optional Feature:
- Macro: FAST_GPIO_IRQ_EN.
- When defined:
  - adds output port irq (1 bit);
  - adds register 0x05 IRQ_MASK (bit0 done, bit1 wrap);
  - irq = registered (done & mask0) | (wrap & mask1), updated one cycle after the flag or mask changes.
- When undefined: no irq port, 0x05 reads 0, and writes to 0x05 are ignored.

Decomposition:
- Package fast_gpio_pkg holds:
  - register address localparams;
  - CTRL and STATUS bit indices;
  - state enum (IDLE, RUN).
- Sub-module fast_gpio_sync: parametrised WIDTH-bit 2-flop synchroniser with clk and reset.

Test Plan:
- Reset, then read every mapped register → all read 0; rvalid pulses one cycle after each read; gpio_out=0 and gpio_oe=0.
- DIR=0xFFFF_FFFF, OUT[0..2]={0xA5A5_0001, 0xA5A5_0002, 0xA5A5_0003}, DIV=1, LEN=3, one-shot START:
  - gpio_out shows each value for exactly 2 cycles;
  - busy falls 6 cycles after START;
  - done=1; gpio_out holds 0xA5A5_0003.
- Continuous, LEN=2, DIV=0, gpio_in constant 0x0000_00F0:
  - gpio_out alternates OUT[0]/OUT[1] every cycle;
  - wrap sets;
  - IN[0] and IN[1] read 0x0000_00F0.
- STOP mid-slot at idx=2 → busy drops at the write edge; IN[2] unchanged; done=0; gpio_out held.
- CTRL write with START|STOP → stays IDLE. LEN=0 with DEPTH=4 → sequence covers 4 slots. Write DIV during RUN → slot timing unchanged until the next START.
- Assert reset mid-RUN → all outputs 0 immediately, without waiting for a clock edge. With FAST_GPIO_IRQ_EN and mask=1: one-shot completion → irq=1 one cycle after done; clearing done → irq=0.
